// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel scanner: resolution defaults, triangle
// record field offsets, scanner state type and small signed helpers.
package pixel_pkg;

  localparam int H_RES_DEF = 1280;
  localparam int V_RES_DEF = 720;

  // Triangle record layout: color|p1x|p1y|p2x|p2y|p3x|p3y|P|nx|ny|nz
  localparam int unsigned P1X_MSB = 143;
  localparam int unsigned P1X_LSB = 128;
  localparam int unsigned P1Y_MSB = 127;
  localparam int unsigned P1Y_LSB = 112;
  localparam int unsigned P2X_MSB = 111;
  localparam int unsigned P2X_LSB = 96;
  localparam int unsigned P2Y_MSB = 95;
  localparam int unsigned P2Y_LSB = 80;
  localparam int unsigned P3X_MSB = 79;
  localparam int unsigned P3X_LSB = 64;
  localparam int unsigned P3Y_MSB = 63;
  localparam int unsigned P3Y_LSB = 48;

  // Contiguous vertex slice handed to the bounding-box logic
  localparam int unsigned VERT_LSB = P3Y_LSB;
  localparam int unsigned VERT_W   = P1X_MSB - P3Y_LSB + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // 16-bit vertex coordinate widened to 17 bits so min/max/clip never overflow
  function automatic logic signed [16:0] sx17(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic signed [16:0] min3(input logic signed [16:0] a,
                                              input logic signed [16:0] b,
                                              input logic signed [16:0] c);
    logic signed [16:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [16:0] max3(input logic signed [16:0] a,
                                              input logic signed [16:0] b,
                                              input logic signed [16:0] c);
    logic signed [16:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [16:0] clip17(input logic signed [16:0] v,
                                                input logic signed [16:0] lim);
    if (v < 17'sd0) begin
      return 17'sd0;
    end else if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/pixel_scanner_bbox_clip.sv
// Combinational bounding box of a triangle: signed min/max of the three
// vertices, clipped to the screen, plus off-screen (skip) and vertical-line
// (degenerate) flags. The scanner registers these outputs in SETUP.
module bbox_clip
  import pixel_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic [VERT_W-1:0] verts_i,
  output logic [10:0]       xmin_o,
  output logic [10:0]       xmax_o,
  output logic [9:0]        ymin_o,
  output logic [9:0]        ymax_o,
  output logic              skip_o,
  output logic              degen_o
);

  localparam logic signed [16:0] XLIM = 17'(H_RES - 1);
  localparam logic signed [16:0] YLIM = 17'(V_RES - 1);

  logic signed [16:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic signed [16:0] xmin_r, xmax_r, ymin_r, ymax_r;

  // Unclipped box in 17-bit signed arithmetic
  always_comb begin
    p1x    = sx17(verts_i[P1X_MSB-VERT_LSB -: 16]);
    p1y    = sx17(verts_i[P1Y_MSB-VERT_LSB -: 16]);
    p2x    = sx17(verts_i[P2X_MSB-VERT_LSB -: 16]);
    p2y    = sx17(verts_i[P2Y_MSB-VERT_LSB -: 16]);
    p3x    = sx17(verts_i[P3X_MSB-VERT_LSB -: 16]);
    p3y    = sx17(verts_i[P3Y_MSB-VERT_LSB -: 16]);
    xmin_r = min3(p1x, p2x, p3x);
    xmax_r = max3(p1x, p2x, p3x);
    ymin_r = min3(p1y, p2y, p3y);
    ymax_r = max3(p1y, p2y, p3y);
  end

  // Clipped box truncated to screen coordinate widths, plus the flags
  always_comb begin
    xmin_o  = 11'(clip17(xmin_r, XLIM));
    xmax_o  = 11'(clip17(xmax_r, XLIM));
    ymin_o  = 10'(clip17(ymin_r, YLIM));
    ymax_o  = 10'(clip17(ymax_r, YLIM));
    skip_o  = (xmax_r < 17'sd0) || (xmin_r > XLIM) ||
              (ymax_r < 17'sd0) || (ymin_r > YLIM);
    degen_o = (p1x == p2x) && (p2x == p3x);
  end

endmodule

// File: rtl/pixel_scanner.sv
// Pixel scanner: accepts one triangle record, computes its screen-clipped
// bounding box and walks it emitting one pixel coordinate per handshake.
// Optional build macro PIXEL_SCANNER_SERPENTINE_EN: odd rows (relative to
// ymin) run from xmax down to xmin; default build scans every row upward.
module pixel_scanner
  import pixel_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [159:0] triangle_in,
  input  logic         triangle_valid,
  output logic         triangle_ready,
  input  logic         pixel_ready,
  output logic [10:0]  xcoord_out,
  output logic [9:0]   ycoord_out,
  output logic         pixel_out_valid,
  output logic [159:0] triangle_out,
  output logic         busy,
  output logic         done
);

  scan_state_e  state_q, state_d;
  logic [159:0] tri_q, tri_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [10:0]  x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [9:0]   y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
`ifdef PIXEL_SCANNER_SERPENTINE_EN
  logic         rev_q, rev_d;
`endif

  logic [10:0]  c_xmin, c_xmax;
  logic [9:0]   c_ymin, c_ymax;
  logic         c_skip, c_degen;

  bbox_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_bbox_clip (
    .verts_i (tri_q[P1X_MSB:P3Y_LSB]),
    .xmin_o  (c_xmin),
    .xmax_o  (c_xmax),
    .ymin_o  (c_ymin),
    .ymax_o  (c_ymax),
    .skip_o  (c_skip),
    .degen_o (c_degen)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tri_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
`ifdef PIXEL_SCANNER_SERPENTINE_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
`ifdef PIXEL_SCANNER_SERPENTINE_EN
      rev_q   <= rev_d;
`endif
    end
  end

  // Next-state logic: accept, register box, raster walk, completion
  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
`ifdef PIXEL_SCANNER_SERPENTINE_EN
    rev_d   = rev_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (triangle_valid) begin
          tri_d   = triangle_in;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        xmin_d = c_xmin;
        xmax_d = c_xmax;
        ymin_d = c_ymin;
        ymax_d = c_ymax;
        x_d    = c_xmin;
        y_d    = c_ymin;
`ifdef PIXEL_SCANNER_SERPENTINE_EN
        rev_d  = 1'b0;
`endif
        state_d = (c_skip || c_degen) ? DONE : SCAN;
      end
      SCAN: begin
        if (pixel_ready) begin
`ifdef PIXEL_SCANNER_SERPENTINE_EN
          // Row turn keeps x at the row end and flips direction
          if (!rev_q && (x_q < xmax_q)) begin
            x_d = x_q + 11'd1;
          end else if (rev_q && (x_q > xmin_q)) begin
            x_d = x_q - 11'd1;
          end else if (y_q < ymax_q) begin
            y_d   = y_q + 10'd1;
            rev_d = ~rev_q;
          end else begin
            state_d = DONE;
          end
`else
          if (x_q < xmax_q) begin
            x_d = x_q + 11'd1;
          end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + 10'd1;
          end else begin
            state_d = DONE;
          end
`endif
        end
      end
      DONE: begin
        // done/busy are registered, so the pulse appears as we re-enter IDLE
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mapping; ready is forced low while reset is asserted
  always_comb begin
    triangle_ready  = (state_q == IDLE) && rst_n;
    pixel_out_valid = (state_q == SCAN);
    xcoord_out      = pixel_out_valid ? x_q : '0;
    ycoord_out      = pixel_out_valid ? y_q : '0;
    triangle_out    = tri_q;
    busy            = busy_q;
    done            = done_q;
  end

endmodule

// File: doc/pixel_scanner.md
Name: pixel_scanner

Overview:
- Producer side of the per-pixel coverage stream. Accepts one 160-bit triangle record and computes its screen-clipped bounding box.
- Walks the box in raster order, emitting xcoord/ycoord with a valid strobe to the downstream coverage tester.
- Holds the triangle record stable alongside each pixel so the tester can use it unregistered.
- Signals completion per triangle. Sits between the triangle FIFO and the coverage tester.

Parameters:
- H_RES, 1280, horizontal resolution; x clip upper bound is H_RES-1.
- V_RES, 720, vertical resolution; y clip upper bound is V_RES-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- triangle_in  input  160  color|p1x|p1y|p2x|p2y|p3x|p3y|P|nx|ny|nz; p1x[143:128], p1y[127:112], p2x[111:96], p2y[95:80], p3x[79:64], p3y[63:48], each signed 16-bit
- triangle_valid  input  1  triangle_in is valid
- triangle_ready  output  1  scanner accepts a triangle this cycle
- pixel_ready  input  1  downstream accepts the current pixel
- xcoord_out  output  11  pixel x
- ycoord_out  output  10  pixel y
- pixel_out_valid  output  1  xcoord_out/ycoord_out are valid
- triangle_out  output  160  registered copy of the accepted triangle, stable from acceptance until the next acceptance
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle pulse after the last pixel transfers, or after a skipped triangle

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE.
  - All outputs are 0, including triangle_out and busy.
  - triangle_ready is 0 while in reset.
- Reset mid-scan abandons the triangle. No done pulse is issued for it.
- FSM states: IDLE, SETUP, SCAN, DONE.
- IDLE:
  - triangle_ready=1.
  - On triangle_valid: register triangle_in into triangle_out, set busy=1, go to SETUP.
- SETUP (1 cycle): register xmin/xmax/ymin/ymax = signed min/max of the three vertices.
  - Clip to [0,H_RES-1] and [0,V_RES-1].
  - Skip condition: pre-clip xmax<0, xmin>H_RES-1, ymax<0, or ymin>V_RES-1.
  - Degenerate condition: p1x==p2x==p3x (vertical line).
  - On skip or degenerate, go to DONE with no pixels emitted. Otherwise load x=xmin, y=ymin and go to SCAN.
- SCAN: pixel_out_valid=1.
  - A transfer occurs when pixel_out_valid && pixel_ready.
  - While pixel_ready=0, coordinates and valid hold unchanged.
  - On transfer: if x<xmax then x++. Else x=xmin and y++.
  - The transfer at (xmax,ymax) goes to DONE.
  - Box arithmetic uses signed 17-bit to avoid overflow. Outputs are truncated to 11/10 bits after clipping.
- DONE (1 cycle): done=1, busy=0 on exit, go to IDLE.
- Throughput and latency:
  - One pixel per cycle when pixel_ready=1 continuously.
  - First pixel is valid 2 cycles after the acceptance edge.
  - Pixel count is (xmax-xmin+1)*(ymax-ymin+1).
- Single-pixel box (xmin==xmax, ymin==ymax): exactly one pixel, then DONE.
- triangle_ready is 0 outside IDLE, so a new triangle is accepted no earlier than the cycle after DONE.

Optional Feature:
- Macro: PIXEL_SCANNER_SERPENTINE_EN.
- With the macro: odd-indexed rows (relative to ymin) scan from xmax down to xmin. The row turn keeps the x at the row end and increments y. The last pixel is whichever row end is reached on row ymax.
- Without the macro: every row scans from xmin up to xmax.
- Pixel count and the handshake are identical in both builds.

Decomposition:
- Package pixel_pkg:
  - H_RES/V_RES defaults.
  - Triangle field bit-offset localparams (P1X_MSB ... P3Y_LSB).
  - Scanner state enum type.
- Sub-module bbox_clip: combinational min/max/clip plus the skip/degenerate flags. Its outputs are registered by the scanner in SETUP.

Test Plan:
1. Triangle (10,10),(13,10),(10,12), pixel_ready=1 → 12 pixels (10..13 × 10..12) in raster order. First valid 2 cycles after acceptance; one done pulse.
2. Same triangle with pixel_ready toggled every cycle → identical 12-pixel sequence, coordinates held during stalls, no pixel dropped or duplicated.
3. Triangle (-5,-5),(2,-5),(-5,1) → clipped to x 0..2, y 0..1: 6 pixels, first at (0,0).
4. Triangle entirely at x≥1300, and triangle (7,0),(7,5),(7,9) → zero pixel_out_valid, done exactly 3 cycles after acceptance.
5. Deassert rst_n mid-scan of case 1 → outputs 0 immediately, no done. After release, a new triangle scans correctly from its first pixel.
6. PIXEL_SCANNER_SERPENTINE_EN build, case 1 triangle → row 10 gives x 10..13, row 11 gives 13..10, row 12 gives 10..13; last pixel (13,12).
